// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann constants and types for the distribution RAM datapath.
package lbm_pkg;
  localparam int Q          = 9;
  localparam int DIST_WIDTH = 32;
  localparam int NODE_WIDTH = Q * DIST_WIDTH;
  localparam int NX_DEFAULT = 16;
  localparam int NY_DEFAULT = 16;

  typedef logic signed [Q-1:0][DIST_WIDTH-1:0] node_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } rd_state_e;
endpackage

// File: rtl/node_fifo2.sv
// Two-entry first-word-fall-through FIFO for {node word, x, y, last}.
module node_fifo2
  import lbm_pkg::*;
#(
  parameter int W = NODE_WIDTH + 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/distribution_reader.sv
// Raster-order read engine: sweeps NX*NY nodes out of the distribution RAM
// and streams each node word with its coordinates over valid/ready.
module distribution_reader
  import lbm_pkg::*;
#(
  parameter int NX            = NX_DEFAULT,
  parameter int NY            = NY_DEFAULT,
  parameter int ADDRESS_WIDTH = $clog2(NX * NY * Q),
  parameter int DATA_WIDTH    = NODE_WIDTH,
  localparam int XW           = (NX > 1) ? $clog2(NX) : 1,
  localparam int YW           = (NY > 1) ? $clog2(NY) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_we,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic [DATA_WIDTH-1:0]    node_data,
  output logic [XW-1:0]            node_x,
  output logic [YW-1:0]            node_y,
  output logic                     node_valid,
  output logic                     node_last,
  input  logic                     node_ready
);
  localparam int            EW    = DATA_WIDTH + XW + YW + 1;
  localparam logic [XW-1:0] X_MAX = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(NY - 1);

  rd_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [XW-1:0]            x_q, x_d, fl_x_q, fl_x_d;
  logic [YW-1:0]            y_q, y_d, fl_y_q, fl_y_d;
  logic                     fl_last_q, fl_last_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;
  logic [EW-1:0]            head;
  logic [1:0]               count;
  logic [2:0]               occ;
  logic                     pop, issue;

  node_fifo2 #(.W(EW)) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (inflight_q),
    .push_data ({ram_data_out, fl_x_q, fl_y_q, fl_last_q}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign node_valid = (count != 2'd0);
  assign pop        = node_valid && node_ready;
  assign {node_data, node_x, node_y, node_last} = head;

  // ram_address always holds the next node to fetch; an issue is the cycle the
  // RAM samples it, so the word arrives while inflight_q is high.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    x_d       = x_q;
    y_d       = y_q;
    fl_x_d    = fl_x_q;
    fl_y_d    = fl_y_q;
    fl_last_d = fl_last_q;
    inflight_d = 1'b0;
    done_d    = 1'b0;
    issue     = 1'b0;
    occ       = {2'b00, inflight_q} + {1'b0, count};
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          base_d  = base_addr;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_RUN: begin
        issue = occ < (3'd2 + {2'b00, pop});
        if (issue) begin
          inflight_d = 1'b1;
          fl_x_d     = x_q;
          fl_y_d     = y_q;
          fl_last_d  = (x_q == X_MAX) && (y_q == Y_MAX);
          if (x_q == X_MAX) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (y_q == Y_MAX) state_d = ST_DRAIN;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop && node_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ram_address_d = base_d + ADDRESS_WIDTH'(y_d) * ADDRESS_WIDTH'(NX) + ADDRESS_WIDTH'(x_d);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      ram_address_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fl_x_q        <= '0;
      fl_y_q        <= '0;
      fl_last_q     <= 1'b0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      ram_address_q <= ram_address_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fl_x_q        <= fl_x_d;
      fl_y_q        <= fl_y_d;
      fl_last_q     <= fl_last_d;
      inflight_q    <= inflight_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign ram_address = ram_address_q;
  assign ram_we      = 1'b0;
endmodule
